hash_loader: RTL and testbench

- Serial receive end of the board's USART link; counterpart of the result transmitter.
- Receives a framed 128-bit target MD5 digest from the host, validates it and presents it to the brute-force generator as a stable compare value, replacing the hard-coded target.
- Contains an oversampling UART receiver and a frame parser with a shadow buffer.

---
 rtl/md5_link_pkg.sv | 44 ++++
 rtl/hash_loader_if.sv | 22 ++
 rtl/usart_rx.sv | 159 +++++++++++++++
 rtl/hash_loader.sv | 141 ++++++++++++++
 tb/tb_hash_loader.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/md5_link_pkg.sv
// Shared definitions for the MD5 USART link: state encodings, frame constants, baud divider.
// HASH_LOADER_PARITY_EN adds the receiver parity state.
package md5_link_pkg;

   localparam int unsigned HASH_BYTES = 16;
   localparam int unsigned HASH_BITS  = HASH_BYTES * 8;
   localparam logic [7:0]  SYNC_BYTE  = 8'hA5;

   localparam logic [2:0] RX_IDLE_ENC  = 3'd0;
   localparam logic [2:0] RX_START_ENC = 3'd1;
   localparam logic [2:0] RX_DATA_ENC  = 3'd2;
   localparam logic [2:0] RX_STOP_ENC  = 3'd4;
`ifdef HASH_LOADER_PARITY_EN
   localparam logic [2:0] RX_PAR_ENC   = 3'd3;
`endif

   localparam logic [1:0] P_SYNC_ENC = 2'd0;
   localparam logic [1:0] P_HASH_ENC = 2'd1;
   localparam logic [1:0] P_SUM_ENC  = 2'd2;

   typedef enum logic [2:0] {
      R_IDLE  = RX_IDLE_ENC,
      R_START = RX_START_ENC,
      R_DATA  = RX_DATA_ENC,
`ifdef HASH_LOADER_PARITY_EN
      R_PAR   = RX_PAR_ENC,
`endif
      R_STOP  = RX_STOP_ENC
   } rx_state_e;

   typedef enum logic [1:0] {
      P_SYNC = P_SYNC_ENC,
      P_HASH = P_HASH_ENC,
      P_SUM  = P_SUM_ENC
   } p_state_e;

   // 16x oversample divider, rounded to nearest; never below 1
   function automatic int unsigned clk_div(input int unsigned clock_freq, input int unsigned baud);
      int unsigned d;
      d = (clock_freq + baud * 8) / (baud * 16);
      return (d == 0) ? 1 : d;
   endfunction

endpackage

// File: rtl/hash_loader_if.sv
// Host-link bundle of hash_loader: serial line in, loaded target digest and status out.
interface hash_loader_if;
   import md5_link_pkg::*;

   logic                 rx;
   logic                 rx_led;
   logic [0:HASH_BITS-1] target_hash;
   logic                 target_valid;
   logic                 target_load;
   logic                 frame_err;
   logic                 busy;

   modport master (
      output rx,
      input  rx_led, target_hash, target_valid, target_load, frame_err, busy
   );

   modport slave (
      input  rx,
      output rx_led, target_hash, target_valid, target_load, frame_err, busy
   );
endinterface

// File: rtl/usart_rx.sv
// Oversampling UART receiver: 2-flop synchronizer, 16x tick divider, byte FSM.
// HASH_LOADER_PARITY_EN selects 8E1 framing instead of 8N1.
module usart_rx
   import md5_link_pkg::*;
#(
   parameter int unsigned tick_div = 17
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data,
   output logic       byte_valid,
   output logic       err,
   output logic       active
);

   localparam int unsigned DIV_W = (tick_div > 1) ? $clog2(tick_div) : 1;

   logic [1:0]       rx_sync;
   logic             rx_s;
   logic [DIV_W-1:0] div_cnt;
   logic             tick;

   rx_state_e  state, state_d;
   logic [3:0] tcnt, tcnt_d;
   logic [2:0] bit_idx, bit_d;
   logic [7:0] shreg, shreg_d;
   logic [7:0] data_d;
   logic       valid_d, err_d;
`ifdef HASH_LOADER_PARITY_EN
   logic       par_err, par_err_d;
`endif

   // Line resynchronization; idle level is high
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rx_sync <= 2'b11;
      else       rx_sync <= {rx_sync[0], rx};
   end
   assign rx_s = rx_sync[1];

   // Free-running oversample strobe
   always_ff @(posedge clk or posedge reset) begin
      if (reset)     div_cnt <= '0;
      else if (tick) div_cnt <= '0;
      else           div_cnt <= div_cnt + DIV_W'(1);
   end
   assign tick = (div_cnt == DIV_W'(tick_div - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= R_IDLE;
         tcnt       <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         data       <= '0;
         byte_valid <= 1'b0;
         err        <= 1'b0;
         active     <= 1'b0;
`ifdef HASH_LOADER_PARITY_EN
         par_err    <= 1'b0;
`endif
      end else begin
         state      <= state_d;
         tcnt       <= tcnt_d;
         bit_idx    <= bit_d;
         shreg      <= shreg_d;
         data       <= data_d;
         byte_valid <= valid_d;
         err        <= err_d;
         active     <= (state_d != R_IDLE);
`ifdef HASH_LOADER_PARITY_EN
         par_err    <= par_err_d;
`endif
      end
   end

   // tcnt is 4 bits, so the 16-tick bit period wraps it back to zero by itself
   always_comb begin
      state_d = state;
      tcnt_d  = tcnt;
      bit_d   = bit_idx;
      shreg_d = shreg;
      data_d  = data;
      valid_d = 1'b0;
      err_d   = 1'b0;
`ifdef HASH_LOADER_PARITY_EN
      par_err_d = par_err;
`endif
      case (state)
         R_IDLE: begin
            if (!rx_s) begin
               state_d = R_START;
               tcnt_d  = '0;
`ifdef HASH_LOADER_PARITY_EN
               par_err_d = 1'b0;
`endif
            end
         end
         R_START: begin
            if (tick) begin
               if (tcnt == 4'd7) begin
                  tcnt_d  = '0;
                  bit_d   = '0;
                  state_d = rx_s ? R_IDLE : R_DATA;
               end else begin
                  tcnt_d = tcnt + 4'd1;
               end
            end
         end
         R_DATA: begin
            if (tick) begin
               tcnt_d = tcnt + 4'd1;
               if (tcnt == 4'd15) begin
                  shreg_d = {rx_s, shreg[7:1]};
                  bit_d   = bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
`ifdef HASH_LOADER_PARITY_EN
                     state_d = R_PAR;
`else
                     state_d = R_STOP;
`endif
                  end
               end
            end
         end
`ifdef HASH_LOADER_PARITY_EN
         R_PAR: begin
            if (tick) begin
               tcnt_d = tcnt + 4'd1;
               if (tcnt == 4'd15) begin
                  par_err_d = (rx_s != ^shreg);
                  state_d   = R_STOP;
               end
            end
         end
`endif
         R_STOP: begin
            if (tick) begin
               tcnt_d = tcnt + 4'd1;
               if (tcnt == 4'd15) begin
                  state_d = R_IDLE;
`ifdef HASH_LOADER_PARITY_EN
                  if (rx_s && !par_err) begin
`else
                  if (rx_s) begin
`endif
                     valid_d = 1'b1;
                     data_d  = shreg;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
         end
         default: state_d = R_IDLE;
      endcase
   end

endmodule

// File: rtl/hash_loader.sv
// Receives a framed MD5 target digest over the USART link and presents it as a stable compare value.
// Frame: sync byte, 16 digest bytes, XOR checksum. HASH_LOADER_PARITY_EN enables 8E1 in usart_rx.
module hash_loader
   import md5_link_pkg::*;
#(
   parameter int unsigned clock_freq     = 16000000,
   parameter int unsigned baud           = 57600,
   parameter logic [7:0]  sync_byte      = SYNC_BYTE,
   parameter int unsigned timeout_cycles = 1600000
) (
   input  logic           clk,
   input  logic           reset,
   hash_loader_if.slave   bus
);

   localparam int unsigned TICK_DIV = clk_div(clock_freq, baud);
   localparam int unsigned IDLE_W   = $clog2(timeout_cycles + 1);
   localparam int unsigned IDX_W    = $clog2(HASH_BYTES);

   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_err;
   logic       rx_active;

   usart_rx #(
      .tick_div (TICK_DIV)
   ) u_usart_rx (
      .clk        (clk),
      .reset      (reset),
      .rx         (bus.rx),
      .data       (rx_data),
      .byte_valid (rx_valid),
      .err        (rx_err),
      .active     (rx_active)
   );

   logic [IDLE_W-1:0] idle_cnt;
   logic              timeout;

   p_state_e                     p_state, p_state_d;
   logic [IDX_W-1:0]             idx, idx_d;
   logic [7:0]                   acc, acc_d;
   logic [0:HASH_BYTES-1][7:0]   shadow;
   logic                         shadow_we;
   logic                         load_d, err_d;
   logic [0:HASH_BITS-1]         hash_q;
   logic                         valid_q, load_q, err_q, busy_q;

   // Clocks since the last received byte; saturates at the limit
   always_ff @(posedge clk or posedge reset) begin
      if (reset)         idle_cnt <= '0;
      else if (rx_valid) idle_cnt <= '0;
      else if (!timeout) idle_cnt <= idle_cnt + IDLE_W'(1);
   end
   assign timeout = (idle_cnt == IDLE_W'(timeout_cycles));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p_state <= P_SYNC;
         idx     <= '0;
         acc     <= '0;
         hash_q  <= '0;
         valid_q <= 1'b0;
         load_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         p_state <= p_state_d;
         idx     <= idx_d;
         acc     <= acc_d;
         load_q  <= load_d;
         err_q   <= err_d;
         busy_q  <= (p_state_d != P_SYNC);
         valid_q <= valid_q | load_d;
         if (load_d) hash_q <= shadow;
      end
   end

   // Shadow buffer keeps partial frames away from target_hash
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          shadow      <= '0;
      else if (shadow_we) shadow[idx] <= rx_data;
   end

   // Byte arrival is tested before timeout so a coincident byte wins
   always_comb begin
      p_state_d = p_state;
      idx_d     = idx;
      acc_d     = acc;
      shadow_we = 1'b0;
      load_d    = 1'b0;
      err_d     = 1'b0;
      case (p_state)
         P_SYNC: begin
            if (rx_err) begin
               err_d = 1'b1;
            end else if (rx_valid && (rx_data == sync_byte)) begin
               idx_d     = '0;
               acc_d     = '0;
               p_state_d = P_HASH;
            end
         end
         P_HASH: begin
            if (rx_err) begin
               err_d     = 1'b1;
               p_state_d = P_SYNC;
            end else if (rx_valid) begin
               shadow_we = 1'b1;
               acc_d     = acc ^ rx_data;
               idx_d     = idx + IDX_W'(1);
               if (idx == IDX_W'(HASH_BYTES - 1)) p_state_d = P_SUM;
            end else if (timeout) begin
               err_d     = 1'b1;
               p_state_d = P_SYNC;
            end
         end
         P_SUM: begin
            if (rx_err) begin
               err_d     = 1'b1;
               p_state_d = P_SYNC;
            end else if (rx_valid) begin
               if (rx_data == acc) load_d = 1'b1;
               else                err_d  = 1'b1;
               p_state_d = P_SYNC;
            end else if (timeout) begin
               err_d     = 1'b1;
               p_state_d = P_SYNC;
            end
         end
         default: p_state_d = P_SYNC;
      endcase
   end

   assign bus.rx_led       = rx_active;
   assign bus.target_hash  = hash_q;
   assign bus.target_valid = valid_q;
   assign bus.target_load  = load_q;
   assign bus.frame_err    = err_q;
   assign bus.busy         = busy_q;

endmodule

// File: tb/tb_hash_loader.sv
// Self-checking bench for hash_loader: directed frames plus random digests against a frame-level model.
// Honours HASH_LOADER_PARITY_EN when sending bytes.
module tb_hash_loader;

   localparam int unsigned CLK_FREQ = 32000000;
   localparam int unsigned BAUD     = 1000000;
   localparam int unsigned TIMEOUT  = 2000;
   localparam int          BIT      = 32;   // clocks per bit: divider 2 x 16

   logic clk = 1'b0;
   logic reset = 1'b1;

   hash_loader_if bus();

   hash_loader #(
      .clock_freq     (CLK_FREQ),
      .baud           (BAUD),
      .sync_byte      (8'hA5),
      .timeout_cycles (TIMEOUT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int load_cnt = 0;
   int err_cnt  = 0;
   always @(posedge clk) begin
      if (bus.target_load) load_cnt = load_cnt + 1;
      if (bus.frame_err)   err_cnt  = err_cnt + 1;
   end

   int vectors     = 0;
   int miscompares = 0;

   logic [127:0] exp_hash;
   logic         exp_valid;
   logic [7:0]   dig [16];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bad_stop);
      bus.rx = 1'b0; idle(BIT);
      for (int i = 0; i < 8; i++) begin
         bus.rx = b[i]; idle(BIT);
      end
`ifdef HASH_LOADER_PARITY_EN
      bus.rx = ^b; idle(BIT);
`endif
      if (bad_stop) begin
         bus.rx = 1'b0; idle(BIT * 3 / 4);
         bus.rx = 1'b1; idle(BIT / 4);
      end else begin
         bus.rx = 1'b1; idle(BIT);
      end
   endtask

`ifdef HASH_LOADER_PARITY_EN
   task automatic send_bad_parity(input logic [7:0] b);
      bus.rx = 1'b0; idle(BIT);
      for (int i = 0; i < 8; i++) begin
         bus.rx = b[i]; idle(BIT);
      end
      bus.rx = ~(^b); idle(BIT);
      bus.rx = 1'b1; idle(BIT);
   endtask
`endif

   function automatic logic [7:0] xor_sum();
      logic [7:0] s = 8'h00;
      for (int i = 0; i < 16; i++) s = s ^ dig[i];
      return s;
   endfunction

   function automatic logic [127:0] pack_dig();
      logic [127:0] h = '0;
      for (int i = 0; i < 16; i++) h = {h[119:0], dig[i]};
      return h;
   endfunction

   task automatic random_dig();
      for (int i = 0; i < 16; i++) dig[i] = 8'($urandom_range(0, 255));
   endtask

   // Sends a whole frame from dig[] and checks the outcome against the frame rules
   task automatic run_frame(input string tag, input bit good);
      int l0, e0;
      logic [7:0] sum;
      l0  = load_cnt;
      e0  = err_cnt;
      sum = xor_sum();
      if (!good) sum = sum ^ 8'($urandom_range(1, 255));
      send_byte(8'hA5, 1'b0);
      for (int i = 0; i < 16; i++) begin
         send_byte(dig[i], 1'b0);
         if (i == 7) begin
            chk({tag, "_mid_hash"}, bus.target_hash, exp_hash);
            chk({tag, "_mid_busy"}, 128'(bus.busy), 128'd1);
         end
      end
      send_byte(sum, 1'b0);
      idle(4);
      if (good) begin
         exp_hash  = pack_dig();
         exp_valid = 1'b1;
      end
      chk({tag, "_hash"},  bus.target_hash, exp_hash);
      chk({tag, "_valid"}, 128'(bus.target_valid), 128'(exp_valid));
      chk({tag, "_loads"}, 128'(load_cnt - l0), good ? 128'd1 : 128'd0);
      chk({tag, "_errs"},  128'(err_cnt - e0),  good ? 128'd0 : 128'd1);
      chk({tag, "_busy"},  128'(bus.busy), 128'd0);
   endtask

   task automatic set_known();
      logic [127:0] k;
      k = 128'h9ffaf8351cd571fabeb210c0170608ef;
      for (int i = 0; i < 16; i++) dig[i] = k[127 - 8*i -: 8];
   endtask

   initial begin
      int l0, e0;
      bus.rx    = 1'b1;
      exp_hash  = '0;
      exp_valid = 1'b0;
      idle(3);
      reset = 1'b0;
      idle(2);

      chk("rst_hash",  bus.target_hash, 128'd0);
      chk("rst_valid", 128'(bus.target_valid), 128'd0);
      chk("rst_load",  128'(bus.target_load), 128'd0);
      chk("rst_err",   128'(bus.frame_err), 128'd0);
      chk("rst_busy",  128'(bus.busy), 128'd0);
      chk("rst_led",   128'(bus.rx_led), 128'd0);

      // Reference frame with checksum c0
      set_known();
      chk("known_sum", 128'(xor_sum()), 128'hc0);
      run_frame("known", 1'b1);
      chk("known_const", bus.target_hash, 128'h9ffaf8351cd571fabeb210c0170608ef);

      // Same body, checksum 00
      l0 = load_cnt; e0 = err_cnt;
      send_byte(8'hA5, 1'b0);
      for (int i = 0; i < 16; i++) send_byte(dig[i], 1'b0);
      send_byte(8'h00, 1'b0);
      idle(4);
      chk("badsum_errs",  128'(err_cnt - e0), 128'd1);
      chk("badsum_loads", 128'(load_cnt - l0), 128'd0);
      chk("badsum_hash",  bus.target_hash, exp_hash);
      chk("badsum_valid", 128'(bus.target_valid), 128'd1);
      chk("badsum_busy",  128'(bus.busy), 128'd0);

      // Junk ahead of the sync byte is ignored silently
      e0 = err_cnt;
      send_byte(8'h3C, 1'b0);
      send_byte(8'h11, 1'b0);
      chk("junk_busy", 128'(bus.busy), 128'd0);
      chk("junk_errs", 128'(err_cnt - e0), 128'd0);
      run_frame("junk", 1'b1);

      // Stalled frame times out
      random_dig();
      l0 = load_cnt; e0 = err_cnt;
      send_byte(8'hA5, 1'b0);
      for (int i = 0; i < 5; i++) send_byte(dig[i], 1'b0);
      chk("to_busy_before", 128'(bus.busy), 128'd1);
      idle(TIMEOUT + 10);
      chk("to_errs",  128'(err_cnt - e0), 128'd1);
      chk("to_loads", 128'(load_cnt - l0), 128'd0);
      chk("to_busy",  128'(bus.busy), 128'd0);
      chk("to_hash",  bus.target_hash, exp_hash);
      idle(TIMEOUT);
      chk("to_sync_quiet", 128'(err_cnt - e0), 128'd1);
      random_dig();
      run_frame("after_to", 1'b1);

      // Short glitch is rejected; bad stop bit on a sync byte is dropped with an error
      e0 = err_cnt;
      bus.rx = 1'b0; idle(BIT / 4);
      bus.rx = 1'b1; idle(2 * BIT);
      chk("glitch_errs", 128'(err_cnt - e0), 128'd0);
      chk("glitch_led",  128'(bus.rx_led), 128'd0);
      chk("glitch_busy", 128'(bus.busy), 128'd0);
      send_byte(8'hA5, 1'b1);
      idle(2 * BIT);
      chk("stop_errs", 128'(err_cnt - e0), 128'd1);
      chk("stop_busy", 128'(bus.busy), 128'd0);
`ifdef HASH_LOADER_PARITY_EN
      send_bad_parity(8'h01);
      idle(BIT);
      chk("par_errs", 128'(err_cnt - e0), 128'd2);
`endif

      // Reset mid-frame discards everything
      random_dig();
      send_byte(8'hA5, 1'b0);
      for (int i = 0; i < 8; i++) send_byte(dig[i], 1'b0);
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      idle(2);
      exp_hash  = '0;
      exp_valid = 1'b0;
      chk("mrst_hash",  bus.target_hash, 128'd0);
      chk("mrst_valid", 128'(bus.target_valid), 128'd0);
      chk("mrst_busy",  128'(bus.busy), 128'd0);
      l0 = load_cnt;
      random_dig();
      run_frame("mrst", 1'b1);
      chk("mrst_loads_total", 128'(load_cnt - l0), 128'd1);

      // Random frames; one carries the sync value as ordinary data
      for (int f = 0; f < 3; f++) begin
         int njunk;
         logic [7:0] j;
         random_dig();
         if (f == 0) dig[3] = 8'hA5;
         njunk = $urandom_range(0, 2);
         for (int k = 0; k < njunk; k++) begin
            j = 8'($urandom_range(0, 255));
            if (j == 8'hA5) j = 8'h5A;
            send_byte(j, 1'b0);
         end
         run_frame($sformatf("rand%0d", f), (f == 0) || ($urandom_range(0, 3) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish, observed running expected finished");
      $fatal(1);
   end

endmodule
